axis_urand_pair_src: RTL
========================

Name: axis_urand_pair_src

Overview:
AXI4-Stream master that produces packed uniform random pairs {u1,u0} for the GGX VNDF sampler's S00 input. Each of the two lanes is its own xorshift32 generator. A start command launches a burst of N beats, or a continuous stream when N=0. The block honours full AXIS backpressure, so it can feed the sampler through a skid buffer or drive it directly.

Parameters:
FRAC_BITS, 32, width of each random lane (u0, u1); only 32 is supported by the xorshift32 taps
C_M00_AXIS_TDATA_WIDTH, 2*FRAC_BITS, packed beat width {u1,u0}
COUNT_BITS, 32, width of the burst-length counter

Ports:
m00_axis_aclk  in  1  clock
m00_axis_aresetn  in  1  reset; asynchronous assert, active-low
start  in  1  one-cycle command pulse; ignored unless idle
stop  in  1  continuous-mode stop request, level or pulse
sample_count  in  COUNT_BITS  beats per burst; 0 = continuous; sampled on accepted start
seed_u0  in  FRAC_BITS  lane-0 seed; sampled on accepted start
seed_u1  in  FRAC_BITS  lane-1 seed; sampled on accepted start
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle pulse when a burst or stream ends
m00_axis_tready  in  1  sink ready
m00_axis_tvalid  out  1  beat valid
m00_axis_tlast  out  1  final beat of a counted burst
m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {u1[63:32], u0[31:0]}
m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all ones

Behaviour:
- Reset (async, active-low): state=IDLE; lane registers, counter and stop latch = 0; tvalid/tlast/busy/done = 0. Reset mid-burst abandons the burst immediately, with no done pulse. The first rising edge after release sees IDLE.
- xorshift32 step per lane: x^=x<<13; x^=x>>17; x^=x<<5, all on 32-bit unsigned values.
- Zero seed substitution: seed_u0==0 becomes 0x2545F491; seed_u1==0 becomes 0x9E3779B9.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start=1 → LOAD. LOAD captures sample_count, both (substituted) seeds into the lane registers, and clears the stop latch.
  - LOAD → RUN unconditionally.
  - RUN: tvalid=1; tdata = current lane registers.
    - On handshake (tvalid&tready): both lanes step, and remaining decrements in counted mode.
    - Counted mode: tlast=1 exactly while remaining==1. A handshake with tlast=1 → DONE.
    - Continuous mode: tlast is always 0. stop=1 in any RUN cycle sets the stop latch. The first handshake at or after the latch is set → DONE; this includes a handshake in the same cycle stop rises. The beat in flight is never withdrawn.
    - stop is ignored in counted mode.
  - DONE: done=1 and tvalid=0 for one cycle → IDLE. busy drops in the same edge.
- Latency: start accepted at edge k gives busy=1 and LOAD after edge k, and tvalid=1 after edge k+1. The first beat is the seeds themselves, before any step.
- AXIS rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake, except via reset.
  - Throughput is 1 beat/clock when tready stays high.
- start while busy is ignored. start in the same cycle as DONE is ignored.
- Counter wrap is impossible: counted mode exits at 1. sample_count=1 gives one beat with tlast=1.

Optional Feature:
URAND_STALL_CNT_EN: when defined, adds output stall_cycles [31:0].
- Counts cycles with tvalid=1 and tready=0.
- Clears on accepted start and on reset; saturates at 0xFFFFFFFF.
- Absent: no port and no counter logic.

Test Plan:
1. Reset, start with sample_count=3, seed_u0=1, seed_u1=1, tready=1 → beats u0=u1=0x00000001, then 0x00042021, then the next step. tlast only on beat 3. done pulses one cycle after beat 3. busy spans LOAD..DONE.
2. seed_u0=0, seed_u1=0, sample_count=1 → single beat tdata=0x9E3779B9_2545F491 with tlast=1.
3. Counted burst of 4 with tready toggling 1,0,0,1,... → tdata/tlast stable through stalls, exactly 4 handshakes; with the macro, stall_cycles equals the number of zero-ready cycles.
4. sample_count=0, tready=1, assert stop on the 10th beat cycle → beat 10 accepted, then DONE. tlast never set. Total 10 beats.
5. Counted burst of 100, deassert aresetn asynchronously mid-stream while tready=0 → tvalid, busy, done drop immediately; after release, start produces the seed beat again.
6. start pulses during RUN and during DONE → ignored: no restart, seeds unchanged, beat count unaffected.

Source files
------------

// File: rtl/axis_urand_pair_src.sv
// axis_urand_pair_src
//   AXI4-Stream master that emits packed uniform random pairs {u1,u0}. Each
//   lane is an independent xorshift32 generator. A start command launches a
//   counted burst of sample_count beats, or a continuous stream when
//   sample_count is zero. In continuous mode a stop request ends the stream.
//   The outputs honour full AXIS backpressure.
//
// Ports
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   start, stop                      : command pulse / continuous-mode stop
//   sample_count, seed_u0, seed_u1   : burst length and lane seeds, taken on an accepted start
//   busy, done                       : activity level / end-of-burst pulse
//   m00_axis_*                       : AXI4-Stream master (tstrb tied to all ones)
//
// Build option
//   URAND_STALL_CNT_EN : adds output stall_cycles, a saturating count of
//                        tvalid&!tready cycles, cleared on accepted start.
module axis_urand_pair_src #(
    parameter int unsigned FRAC_BITS              = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 2 * FRAC_BITS,
    parameter int unsigned COUNT_BITS             = 32
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic [COUNT_BITS-1:0]                 sample_count,
    input  logic [FRAC_BITS-1:0]                  seed_u0,
    input  logic [FRAC_BITS-1:0]                  seed_u1,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
`ifdef URAND_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam logic [FRAC_BITS-1:0] ZERO_SUB_U0 = FRAC_BITS'(32'h2545F491);
    localparam logic [FRAC_BITS-1:0] ZERO_SUB_U1 = FRAC_BITS'(32'h9E3779B9);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [FRAC_BITS-1:0]  lane0;
    logic [FRAC_BITS-1:0]  lane1;
    logic [COUNT_BITS-1:0] remaining;
    logic                  stop_latch;
    logic                  start_accept;
    logic                  handshake;
    logic                  continuous;

    function automatic logic [FRAC_BITS-1:0] xorshift32(input logic [FRAC_BITS-1:0] x);
        logic [FRAC_BITS-1:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    assign start_accept = (state == IDLE) && start;
    assign handshake    = m00_axis_tvalid && m00_axis_tready;
    // A counted burst leaves RUN when remaining hits 1, so remaining==0
    // only ever occurs in RUN for a continuous stream.
    assign continuous   = (remaining == '0);

    // State register
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN: begin
                if (handshake) begin
                    if (continuous) begin
                        if (stop_latch || stop) state_next = DONE;
                    end else if (remaining == COUNT_BITS'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        m00_axis_tvalid = (state == RUN);
        m00_axis_tlast  = (state == RUN) && (remaining == COUNT_BITS'(1));
    end

    assign m00_axis_tdata = {lane1, lane0};
    assign m00_axis_tstrb = '1;

    // Datapath. Seeds and count are captured on the accepting edge (the edge
    // that enters LOAD); the stop latch is cleared there too, which is
    // equivalent to clearing it in LOAD since nothing can set it before RUN.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            lane0      <= '0;
            lane1      <= '0;
            remaining  <= '0;
            stop_latch <= 1'b0;
        end else if (start_accept) begin
            lane0      <= (seed_u0 == '0) ? ZERO_SUB_U0 : seed_u0;
            lane1      <= (seed_u1 == '0) ? ZERO_SUB_U1 : seed_u1;
            remaining  <= sample_count;
            stop_latch <= 1'b0;
        end else if (state == RUN) begin
            if (continuous && stop) begin
                stop_latch <= 1'b1;
            end
            if (handshake) begin
                lane0 <= xorshift32(lane0);
                lane1 <= xorshift32(lane1);
                if (!continuous) begin
                    remaining <= remaining - COUNT_BITS'(1);
                end
            end
        end
    end

`ifdef URAND_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            stall_q <= '0;
        end else if (start_accept) begin
            stall_q <= '0;
        end else if (m00_axis_tvalid && !m00_axis_tready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
